// File: rtl/ycc_pkg.sv
// ycc_pkg: shared constants and types for the YCbCr pixel engine.
// Holds the nine conversion coefficients (indexed by term), the accumulator
// preload constants, the controller state encoding and term decode helpers.
package ycc_pkg;

    localparam int NUM_TERMS = 9;
    localparam int CHANNELS  = 3;

    // Chroma channels are centred on 128 in Q.16 form.
    localparam int CHROMA_OFFSET = 128 << 16;
    // Half an output LSB so that the final arithmetic shift rounds to nearest.
    localparam int ROUND = 1 << 15;

    // Coefficient magnitudes in Q0.16, term order Y(R,G,B), Cb(R,G,B), Cr(R,G,B).
    // Each row sums to 65536 (Y) or 0 (Cb, Cr) once signs apply, so greys map exactly.
    localparam logic [15:0] COEF_MAG [NUM_TERMS] = '{
        16'd19595, 16'd38470, 16'd7471,
        16'd11059, 16'd21709, 16'd32768,
        16'd32768, 16'd27439, 16'd5329
    };

    // 1 = the product is subtracted from the channel accumulator.
    localparam logic COEF_NEG [NUM_TERMS] = '{
        1'b0, 1'b0, 1'b0,
        1'b1, 1'b1, 1'b0,
        1'b0, 1'b1, 1'b1
    };

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_e;

    // Output channel a term accumulates into: 0 = Y, 1 = Cb, 2 = Cr.
    function automatic logic [1:0] term_channel(input logic [3:0] term);
        return 2'(term / 4'd3);
    endfunction

    // Input component a term multiplies: 0 = R, 1 = G, 2 = B.
    function automatic logic [1:0] term_operand(input logic [3:0] term);
        return 2'(term % 4'd3);
    endfunction

endpackage

// File: rtl/serial_shift_add_mac.sv
// serial_shift_add_mac: one signed accumulator lane of the pixel engine.
// Each enabled cycle consumes one operand bit; a set bit adds or subtracts
// the coefficient shifted by that bit's weight. A preload strobe seeds the
// lane with its offset/rounding constant at the start of each pixel.
module serial_shift_add_mac #(
    parameter int ACC_WIDTH   = 32,
    parameter int COEF_WIDTH  = 16,
    parameter int SHIFT_WIDTH = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en_i,
    input  logic                        load_i,
    input  logic signed [ACC_WIDTH-1:0] preload_i,
    input  logic                        op_bit_i,
    input  logic [COEF_WIDTH-1:0]       coef_i,
    input  logic                        neg_i,
    input  logic [SHIFT_WIDTH-1:0]      shift_i,
    output logic signed [ACC_WIDTH-1:0] acc_o
);

    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0] addend;

    // Next accumulator value: preload, signed shift-add, or hold.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        acc_d  = acc_q;
        addend = $signed(ACC_WIDTH'(coef_i) << shift_i);
        if (load_i) begin
            acc_d = preload_i;
        end else if (en_i && op_bit_i) begin
            acc_d = neg_i ? (acc_q - addend) : (acc_q + addend);
        end
    end

    // Accumulator register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignment so all flops sample the same pre-edge values.
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/ycc_pixel_engine.sv
// ycc_pixel_engine: per-pixel RGB -> YCbCr converter without hardware multipliers.
// A controller walks nine coefficient terms, one operand bit per cycle (72 MAC
// cycles), steering each bit into one of three serial shift-add lanes. The
// result is shifted down, clamped to the pixel range and held until accepted.
// Optional feature: define YCC_SATURATE_FLAG_EN to add the sat_flags port.
module ycc_pixel_engine
    import ycc_pkg::*;
#(
    parameter int INPUT_WIDTH = 8,
    parameter int COEF_WIDTH  = 16,
    parameter int ACC_WIDTH   = 32,
    parameter int SCALE       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INPUT_WIDTH-1:0] r_in,
    input  logic [INPUT_WIDTH-1:0] g_in,
    input  logic [INPUT_WIDTH-1:0] b_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INPUT_WIDTH-1:0] y_out,
    output logic [INPUT_WIDTH-1:0] cb_out,
    output logic [INPUT_WIDTH-1:0] cr_out
`ifdef YCC_SATURATE_FLAG_EN
    ,
    output logic [2:0]             sat_flags
`endif
);

    localparam int                          BIT_WIDTH = $clog2(INPUT_WIDTH);
    localparam logic [BIT_WIDTH-1:0]        BIT_LAST  = BIT_WIDTH'(INPUT_WIDTH - 1);
    localparam logic [3:0]                  TERM_LAST = 4'(NUM_TERMS - 1);
    localparam logic signed [ACC_WIDTH-1:0] PIX_MAX   = ACC_WIDTH'((1 << INPUT_WIDTH) - 1);
    localparam logic signed [ACC_WIDTH-1:0] ACC_ZERO  = '0;

    state_e                  state_q, state_d;
    logic [3:0]              term_q, term_d;
    logic [BIT_WIDTH-1:0]    bit_q, bit_d;
    logic [INPUT_WIDTH-1:0]  r_q, r_d, g_q, g_d, b_q, b_d;
    logic                    load;
    logic                    mac_en;
    logic [INPUT_WIDTH-1:0]  operand;
    logic                    op_bit;
    logic [CHANNELS-1:0]     lane_en;

    logic signed [ACC_WIDTH-1:0] acc    [CHANNELS];
    logic signed [ACC_WIDTH-1:0] scaled [CHANNELS];
    logic [INPUT_WIDTH-1:0]      res    [CHANNELS];

    // Controller state, term/bit counters and the latched pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            term_q  <= '0;
            bit_q   <= '0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            term_q  <= term_d;
            bit_q   <= bit_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
        end
    end

    // Next-state logic: accept in IDLE, step bits/terms in MAC, hold in OUT until taken.
    always_comb begin
        state_d = state_q;
        term_d  = term_q;
        bit_d   = bit_q;
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        load    = 1'b0;
        mac_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    r_d     = r_in;
                    g_d     = g_in;
                    b_d     = b_in;
                    term_d  = '0;
                    bit_d   = '0;
                    load    = 1'b1;
                    state_d = MAC;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                if (bit_q == BIT_LAST) begin
                    bit_d = '0;
                    if (term_q == TERM_LAST) begin
                        state_d = OUT;
                    end else begin
                        term_d = term_q + 4'd1;
                    end
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pick the component multiplied by the current term and its current bit.
    always_comb begin
        unique case (term_operand(term_q))
            2'd0:    operand = r_q;
            2'd1:    operand = g_q;
            default: operand = b_q;
        endcase
        op_bit = operand[bit_q];
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_lane
        localparam logic signed [ACC_WIDTH-1:0] PRELOAD =
            (ch == 0) ? ACC_WIDTH'(ROUND) : ACC_WIDTH'(CHROMA_OFFSET + ROUND);

        assign lane_en[ch] = mac_en && (term_channel(term_q) == 2'(ch));

        serial_shift_add_mac #(
            .ACC_WIDTH  (ACC_WIDTH),
            .COEF_WIDTH (COEF_WIDTH),
            .SHIFT_WIDTH(BIT_WIDTH)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .en_i     (lane_en[ch]),
            .load_i   (load),
            .preload_i(PRELOAD),
            .op_bit_i (op_bit),
            .coef_i   (COEF_WIDTH'(COEF_MAG[term_q])),
            .neg_i    (COEF_NEG[term_q]),
            .shift_i  (bit_q),
            .acc_o    (acc[ch])
        );
    end

    // Drop the fractional bits and clamp each channel into the pixel range.
    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            scaled[ch] = acc[ch] >>> SCALE;
            if (scaled[ch] < ACC_ZERO) begin
                res[ch] = '0;
            end else if (scaled[ch] > PIX_MAX) begin
                res[ch] = '1;
            end else begin
                res[ch] = scaled[ch][INPUT_WIDTH-1:0];
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign y_out     = out_valid ? res[0] : '0;
    assign cb_out    = out_valid ? res[1] : '0;
    assign cr_out    = out_valid ? res[2] : '0;

`ifdef YCC_SATURATE_FLAG_EN
    // Flag channels whose value had to be clamped; bit 2 = Y, bit 0 = Cr.
    always_comb begin
        sat_flags = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            sat_flags[CHANNELS-1-ch] = out_valid &&
                ((scaled[ch] < ACC_ZERO) || (scaled[ch] > PIX_MAX));
        end
    end
`endif

endmodule

// File: tb/tb_ycc_pixel_engine.sv
// tb_ycc_pixel_engine: self-checking bench for ycc_pixel_engine.
// A behavioural model converts each accepted pixel with plain integer maths;
// one compare process checks every cycle that out_valid is high.
module tb_ycc_pixel_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       in_ready, out_valid;
    logic [7:0] r_in = '0, g_in = '0, b_in = '0;
    logic [7:0] y_out, cb_out, cr_out;
`ifdef YCC_SATURATE_FLAG_EN
    logic [2:0] sat_flags;
`endif

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
        logic [2:0] sat;
    } pix_t;

    typedef struct {
        pix_t        pix;
        int unsigned acc_cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;

    ycc_pixel_engine dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .r_in     (r_in),
        .g_in     (g_in),
        .b_in     (b_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y_out    (y_out),
        .cb_out   (cb_out),
        .cr_out   (cr_out)
`ifdef YCC_SATURATE_FLAG_EN
        ,
        .sat_flags(sat_flags)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference conversion: signed dot product plus offset, floor by 2^16, clamp.
    function automatic pix_t model(input int r, input int g, input int b);
        longint acc [3];
        logic [7:0] v [3];
        bit s [3];
        pix_t p;
        acc[0] = 19595 * r + 38470 * g + 7471 * b + 32768;
        acc[1] = (128 * 65536 + 32768) - 11059 * r - 21709 * g + 32768 * b;
        acc[2] = (128 * 65536 + 32768) + 32768 * r - 27439 * g - 5329 * b;
        for (int c = 0; c < 3; c++) begin
            longint q;
            q = acc[c] >>> 16;
            s[c] = (q < 0) || (q > 255);
            if (q < 0)        v[c] = 8'd0;
            else if (q > 255) v[c] = 8'd255;
            else              v[c] = 8'(q);
        end
        p.y   = v[0];
        p.cb  = v[1];
        p.cr  = v[2];
        p.sat = {s[0], s[1], s[2]};
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: got no event within bound, expected event", name);
    endtask

    // Hand-computed values that pin the model itself.
    task automatic pin(input string name, input int r, input int g, input int b,
                       input int y, input int cb, input int cr, input int sat);
        pix_t p;
        p = model(r, g, b);
        check({name, "_y"},   32'(p.y),   32'(y));
        check({name, "_cb"},  32'(p.cb),  32'(cb));
        check({name, "_cr"},  32'(p.cr),  32'(cr));
        check({name, "_sat"}, 32'(p.sat), 32'(sat));
    endtask

    // Offer a pixel until accepted; with hold set, in_valid stays high afterwards.
    task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input bit hold, output int unsigned acc_cyc);
        int   budget;
        exp_t e;
        budget = 400;
        @(negedge clk);
        r_in = r;
        g_in = g;
        b_in = b;
        in_valid = 1'b1;
        while (!in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        acc_cyc = cyc;
        if (!in_ready) begin
            fail_now("accept_timeout");
            in_valid = 1'b0;
            return;
        end
        e.pix = model(r, g, b);
        e.acc_cyc = cyc;
        exp_q.push_back(e);
        if (!hold) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int budget;
        budget = 300;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (exp_q.size() != 0) begin
            fail_now("drain_timeout");
            exp_q.delete();
        end
    endtask

    // Compare process: every cycle with out_valid high is checked against the model.
    initial begin : compare
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                prev_valid = 1'b0;
                continue;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_out_valid");
                end else begin
                    e = exp_q[0];
                    if (!prev_valid) check("latency", cyc - e.acc_cyc, 32'd73);
                    check("y_out",  32'(y_out),  32'(e.pix.y));
                    check("cb_out", 32'(cb_out), 32'(e.pix.cb));
                    check("cr_out", 32'(cr_out), 32'(e.pix.cr));
`ifdef YCC_SATURATE_FLAG_EN
                    check("sat_flags", 32'(sat_flags), 32'(e.pix.sat));
`endif
                    check("in_ready_busy", 32'(in_ready), 32'd0);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            prev_valid = out_valid;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [7:0]  dir_r [7] = '{8'd255, 8'd0, 8'd255, 8'd0,   8'd0,   8'd128, 8'd17};
        logic [7:0]  dir_g [7] = '{8'd255, 8'd0, 8'd0,   8'd0,   8'd255, 8'd128, 8'd200};
        logic [7:0]  dir_b [7] = '{8'd255, 8'd0, 8'd0,   8'd255, 8'd0,   8'd128, 8'd90};
        int unsigned a, a_prev;
        int          budget;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y",         32'(y_out),     32'd0);
        check("rst_cb",        32'(cb_out),    32'd0);
        check("rst_cr",        32'(cr_out),    32'd0);
`ifdef YCC_SATURATE_FLAG_EN
        check("rst_sat",       32'(sat_flags), 32'd0);
`endif

        pin("white", 255, 255, 255, 255, 128, 128, 0);
        pin("black", 0,   0,   0,   0,   128, 128, 0);
        pin("red",   255, 0,   0,   76,  85,  255, 1);
        pin("blue",  0,   0,   255, 29,  255, 107, 2);
        pin("green", 0,   255, 0,   150, 44,  21,  0);
        pin("grey",  128, 128, 128, 128, 128, 128, 0);

        // Directed pixels, one at a time.
        for (int i = 0; i < 7; i++) begin
            send(dir_r[i], dir_g[i], dir_b[i], 1'b0, a);
            drain();
        end

        // Reset during MAC discards the pixel.
        send(8'd10, 8'd20, 8'd30, 1'b0, a);
        while (cyc - a < 30) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        repeat (100) @(negedge clk);

        // Backpressure: result held for 10 cycles while in_valid pulses are ignored.
        out_ready = 1'b0;
        send(8'd200, 8'd100, 8'd50, 1'b0, a);
        budget = 100;
        while (!out_valid && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!out_valid) fail_now("bp_out_valid_timeout");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            r_in = 8'($urandom);
            g_in = 8'($urandom);
            b_in = 8'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_released_idle",  32'(in_ready),     32'd1);
        check("bp_released_valid", 32'(out_valid),    32'd0);
        check("bp_popped",         32'(exp_q.size()), 32'd0);
        send(8'd64, 8'd32, 8'd240, 1'b0, a);
        drain();

        // Back-to-back random pixels with in_valid and out_ready held high.
        send(8'($urandom), 8'($urandom), 8'($urandom), 1'b1, a_prev);
        for (int i = 1; i < 6; i++) begin
            send(8'($urandom), 8'($urandom), 8'($urandom), (i < 5), a);
            check("b2b_spacing", a - a_prev, 32'd74);
            a_prev = a;
        end
        drain();

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
